// File: rtl/adjust_key_pkg.sv
// Shared types and defaults for the time-adjust key front-end.
// ADJUST_AUTO_REPEAT_EN adds the REPEAT state for hold-to-repeat.
package adjust_key_pkg;

    localparam int DEF_DEBOUNCE_CYCLES = 4;
    localparam int DEF_REPEAT_DELAY    = 8;
    localparam int DEF_REPEAT_PERIOD   = 4;
    localparam int DEF_CNT_WIDTH       = 8;

`ifdef ADJUST_AUTO_REPEAT_EN
    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_HOLD         = 2'd1,
        ST_REPEAT       = 2'd2,
        ST_WAIT_RELEASE = 2'd3
    } state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_HOLD         = 2'd1,
        ST_WAIT_RELEASE = 2'd3
    } state_e;
`endif

endpackage

// File: rtl/adjust_key_ctrl_debounce.sv
// key_debounce: 2-flop synchronizer followed by a counting debouncer.
// The level flips after DEBOUNCE_CYCLES consecutive differing samples.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_WIDTH       = 8
) (
    input  logic clk_normal,
    input  logic reset_n,
    input  logic key_raw,
    output logic key_db
);

    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic                 sync1_q, sync1_d;
    logic                 sync2_q, sync2_d;
    logic                 db_q, db_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d = key_raw;
        sync2_d = sync1_q;
        db_d    = db_q;
        cnt_d   = '0;
        if (sync2_q != db_q) begin
            if (cnt_q >= LAST) begin
                db_d  = sync2_q;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_normal) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            db_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
        end
    end

    assign key_db = db_q;

endmodule

// File: rtl/adjust_key_ctrl.sv
// Time-adjust button front-end: debounce, single pulses, optional
// hold-to-repeat when ADJUST_AUTO_REPEAT_EN is defined.
module adjust_key_ctrl
    import adjust_key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
    parameter int CNT_WIDTH       = DEF_CNT_WIDTH
) (
    input  logic clk_normal,
    input  logic reset_n,
    input  logic power,
    input  logic enable,
    input  logic key_add,
    input  logic key_sub,
    output logic add_time,
    output logic sub_time,
    output logic key_busy
);

    if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
        $error("adjust_key_ctrl: cycle parameters must be >= 1");
    end

    logic add_db, sub_db;
    logic add_prev_q, add_prev_d;
    logic sub_prev_q, sub_prev_d;
    logic add_rise, sub_rise;
    logic armed, held, other, fire;

    state_e state_q, state_d;
    logic   sel_q, sel_d;
    logic   add_time_q, add_time_d;
    logic   sub_time_q, sub_time_d;
    logic   key_busy_q, key_busy_d;

`ifdef ADJUST_AUTO_REPEAT_EN
    localparam logic [CNT_WIDTH-1:0] DELAY  = CNT_WIDTH'(REPEAT_DELAY);
    localparam logic [CNT_WIDTH-1:0] PERIOD = CNT_WIDTH'(REPEAT_PERIOD);
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d, cnt_inc;
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
`endif

    key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_WIDTH       (CNT_WIDTH)
    ) u_add_db (
        .clk_normal (clk_normal),
        .reset_n    (reset_n),
        .key_raw    (key_add),
        .key_db     (add_db)
    );

    key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_WIDTH       (CNT_WIDTH)
    ) u_sub_db (
        .clk_normal (clk_normal),
        .reset_n    (reset_n),
        .key_raw    (key_sub),
        .key_db     (sub_db)
    );

    assign add_prev_d = add_db;
    assign sub_prev_d = sub_db;
    assign add_rise   = add_db & ~add_prev_q;
    assign sub_rise   = sub_db & ~sub_prev_q;
    assign armed      = power & ~enable;
    // sel_q = 1 means the sub key owns the current press
    assign held       = sel_q ? sub_db : add_db;
    assign other      = sel_q ? add_db : sub_db;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        fire    = 1'b0;
`ifdef ADJUST_AUTO_REPEAT_EN
        cnt_d   = cnt_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
`ifdef ADJUST_AUTO_REPEAT_EN
                cnt_d = '0;
`endif
                if (add_db && sub_db) begin
                    state_d = ST_WAIT_RELEASE;
                end else if (add_rise || sub_rise) begin
                    if (armed) begin
                        state_d = ST_HOLD;
                        sel_d   = sub_rise;
                        fire    = 1'b1;
`ifdef ADJUST_AUTO_REPEAT_EN
                        cnt_d   = CNT_WIDTH'(1);
`endif
                    end else begin
                        state_d = ST_WAIT_RELEASE;
                    end
                end else if (add_db || sub_db) begin
                    state_d = ST_WAIT_RELEASE;
                end
            end
            ST_HOLD: begin
                if (!armed || other) begin
                    state_d = ST_WAIT_RELEASE;
                end else if (!held) begin
                    state_d = ST_IDLE;
                end
`ifdef ADJUST_AUTO_REPEAT_EN
                else if (cnt_q >= DELAY) begin
                    state_d = ST_REPEAT;
                    fire    = 1'b1;
                    cnt_d   = CNT_WIDTH'(1);
                end else begin
                    cnt_d = cnt_inc;
                end
`endif
            end
`ifdef ADJUST_AUTO_REPEAT_EN
            ST_REPEAT: begin
                if (!armed || other) begin
                    state_d = ST_WAIT_RELEASE;
                end else if (!held) begin
                    state_d = ST_IDLE;
                end else if (cnt_q >= PERIOD) begin
                    fire  = 1'b1;
                    cnt_d = CNT_WIDTH'(1);
                end else begin
                    cnt_d = cnt_inc;
                end
            end
`endif
            ST_WAIT_RELEASE: begin
                if (!add_db && !sub_db) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        add_time_d = fire & ~sel_d;
        sub_time_d = fire & sel_d;
        key_busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_normal) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            sel_q      <= 1'b0;
            add_prev_q <= 1'b0;
            sub_prev_q <= 1'b0;
            add_time_q <= 1'b0;
            sub_time_q <= 1'b0;
            key_busy_q <= 1'b0;
`ifdef ADJUST_AUTO_REPEAT_EN
            cnt_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            add_prev_q <= add_prev_d;
            sub_prev_q <= sub_prev_d;
            add_time_q <= add_time_d;
            sub_time_q <= sub_time_d;
            key_busy_q <= key_busy_d;
`ifdef ADJUST_AUTO_REPEAT_EN
            cnt_q      <= cnt_d;
`endif
        end
    end

    assign add_time = add_time_q;
    assign sub_time = sub_time_q;
    assign key_busy = key_busy_q;

endmodule

// File: tb/tb_adjust_key_ctrl.sv
// Directed bench for adjust_key_ctrl; bit n of each mask is the
// output value observed just after edge n of a scenario.
module tb_adjust_key_ctrl;

    logic clk_normal = 1'b0;
    logic reset_n    = 1'b0;
    logic power      = 1'b1;
    logic enable     = 1'b0;
    logic key_add    = 1'b0;
    logic key_sub    = 1'b0;
    logic add_time;
    logic sub_time;
    logic key_busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk_normal = ~clk_normal;

    adjust_key_ctrl dut (
        .clk_normal (clk_normal),
        .reset_n    (reset_n),
        .power      (power),
        .enable     (enable),
        .key_add    (key_add),
        .key_sub    (key_sub),
        .add_time   (add_time),
        .sub_time   (sub_time),
        .key_busy   (key_busy)
    );

    // Keys go high before edge 1; key low after edge *_hi; power drops after pwr_edge.
    task automatic run_seq(input int add_hi, input int sub_hi, input int total,
                           input int pwr_edge, output logic [63:0] am,
                           output logic [63:0] sm, output logic [63:0] bm);
        am = '0;
        sm = '0;
        bm = '0;
        @(negedge clk_normal);
        key_add = (add_hi > 0);
        key_sub = (sub_hi > 0);
        for (int n = 1; n <= total; n++) begin
            @(posedge clk_normal);
            #1;
            am[n] = add_time;
            sm[n] = sub_time;
            bm[n] = key_busy;
            if (n == add_hi) key_add = 1'b0;
            if (n == sub_hi) key_sub = 1'b0;
            if (n == pwr_edge) power = 1'b0;
        end
    endtask

    task automatic settle();
        key_add = 1'b0;
        key_sub = 1'b0;
        power   = 1'b1;
        enable  = 1'b0;
        repeat (20) @(posedge clk_normal);
        #1;
    endtask

    function automatic logic [63:0] span(input int lo, input int hi);
        logic [63:0] m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    task automatic test_reset();
        logic [63:0] am, sm, bm, ea;
        reset_n = 1'b0;
        key_add = 1'b1;
        repeat (2) @(posedge clk_normal);
        #1;
        n_cmp++;
        if (add_time !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_add_time: got %b expected 0", add_time);
        end
        n_cmp++;
        if (sub_time !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_sub_time: got %b expected 0", sub_time);
        end
        n_cmp++;
        if (key_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_key_busy: got %b expected 0", key_busy);
        end
        reset_n = 1'b1;
        run_seq(12, 0, 12, 0, am, sm, bm);
        ea = '0;
        ea[7] = 1'b1;
        n_cmp++;
        if (am !== ea) begin
            n_bad++;
            $display("FAIL reset_release_add: got %h expected %h", am, ea);
        end
        settle();
    endtask

    task automatic test_reset_mid();
        logic [63:0] am, sm, bm, ea;
        run_seq(100, 0, 6, 0, am, sm, bm);
        reset_n = 1'b0;
        @(posedge clk_normal);
        #1;
        n_cmp++;
        if ({add_time, key_busy} !== 2'b00) begin
            n_bad++;
            $display("FAIL mid_reset_outputs: got add=%b busy=%b expected 0 0",
                     add_time, key_busy);
        end
        reset_n = 1'b1;
        run_seq(10, 0, 12, 0, am, sm, bm);
        ea = '0;
        ea[7] = 1'b1;
        n_cmp++;
        if (am !== ea) begin
            n_bad++;
            $display("FAIL mid_reset_fresh_press: got %h expected %h", am, ea);
        end
        settle();
    endtask

    task automatic test_glitch();
        logic [63:0] am, sm, bm;
        run_seq(3, 0, 12, 0, am, sm, bm);
        n_cmp++;
        if (am !== 64'd0) begin
            n_bad++;
            $display("FAIL glitch_add: got %h expected 0", am);
        end
        n_cmp++;
        if (bm !== 64'd0) begin
            n_bad++;
            $display("FAIL glitch_busy: got %h expected 0", bm);
        end
        settle();
    endtask

    task automatic test_single_press();
        logic [63:0] am, sm, bm, ea, eb;
        run_seq(10, 0, 20, 0, am, sm, bm);
        ea = '0;
        ea[7] = 1'b1;
`ifdef ADJUST_AUTO_REPEAT_EN
        // debounced level stays high through edge 15, so one repeat lands
        ea[15] = 1'b1;
`endif
        eb = span(7, 16);
        n_cmp++;
        if (am !== ea) begin
            n_bad++;
            $display("FAIL single_add: got %h expected %h", am, ea);
        end
        n_cmp++;
        if (sm !== 64'd0) begin
            n_bad++;
            $display("FAIL single_sub: got %h expected 0", sm);
        end
        n_cmp++;
        if (bm !== eb) begin
            n_bad++;
            $display("FAIL single_busy: got %h expected %h", bm, eb);
        end
        settle();
    endtask

    task automatic test_auto_repeat();
        logic [63:0] am, sm, bm, es;
        run_seq(0, 24, 34, 0, am, sm, bm);
        es = '0;
        es[7] = 1'b1;
`ifdef ADJUST_AUTO_REPEAT_EN
        es[15] = 1'b1;
        es[19] = 1'b1;
        es[23] = 1'b1;
        es[27] = 1'b1;
`endif
        n_cmp++;
        if (sm !== es) begin
            n_bad++;
            $display("FAIL repeat_sub: got %h expected %h", sm, es);
        end
        n_cmp++;
        if (am !== 64'd0) begin
            n_bad++;
            $display("FAIL repeat_add: got %h expected 0", am);
        end
        n_cmp++;
        if (bm !== span(7, 30)) begin
            n_bad++;
            $display("FAIL repeat_busy: got %h expected %h", bm, span(7, 30));
        end
        settle();
    endtask

    task automatic test_blocked();
        logic [63:0] am, sm, bm, eb;
        eb = span(7, 16);
        for (int k = 0; k < 3; k++) begin
            if (k == 1) enable = 1'b1;
            if (k == 2) power = 1'b0;
            run_seq(10, (k == 0) ? 10 : 0, 20, 0, am, sm, bm);
            n_cmp++;
            if ((am | sm) !== 64'd0) begin
                n_bad++;
                $display("FAIL blocked_pulses case %0d: got add=%h sub=%h expected 0",
                         k, am, sm);
            end
            n_cmp++;
            if (bm !== eb) begin
                n_bad++;
                $display("FAIL blocked_busy case %0d: got %h expected %h", k, bm, eb);
            end
            settle();
        end
    endtask

    task automatic test_power_drop();
        logic [63:0] am, sm, bm, es, eb;
        run_seq(0, 30, 40, 20, am, sm, bm);
        es = '0;
        es[7] = 1'b1;
`ifdef ADJUST_AUTO_REPEAT_EN
        es[15] = 1'b1;
        es[19] = 1'b1;
`endif
        eb = span(7, 36);
        n_cmp++;
        if (sm !== es) begin
            n_bad++;
            $display("FAIL power_drop_sub: got %h expected %h", sm, es);
        end
        n_cmp++;
        if (bm !== eb) begin
            n_bad++;
            $display("FAIL power_drop_busy: got %h expected %h", bm, eb);
        end
        n_cmp++;
        if (am !== 64'd0) begin
            n_bad++;
            $display("FAIL power_drop_add: got %h expected 0", am);
        end
        settle();
    endtask

    initial begin
        test_reset();
        test_reset_mid();
        test_glitch();
        test_single_press();
        test_auto_repeat();
        test_blocked();
        test_power_drop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/adjust_key_ctrl.md
# adjust_key_ctrl

Front-end for the time-adjust buttons of the clock design. Synchronizes and debounces the raw add/sub push-buttons and produces clean single-cycle `add_time` / `sub_time` pulses for the timer chain, with hold-to-auto-repeat. Pulses are emitted only while the clock is powered and paused (`power`=1, `enable`=0), the only mode in which the timers honour adjust requests.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, 4: consecutive stable synchronized samples needed to accept a key level change (≥1).
- `REPEAT_DELAY`, 8: cycles from first pulse to first auto-repeat pulse (≥1).
- `REPEAT_PERIOD`, 4: cycles between subsequent auto-repeat pulses (≥1).
- `CNT_WIDTH`, 8: counter width; must represent max of the three above.

Ports:
- `clk_normal`  in  1  sole clock.
- `reset_n`  in  1  synchronous, active-low reset.
- `power`  in  1  clock powered.
- `enable`  in  1  clock running (1) / paused (0).
- `key_add`  in  1  raw asynchronous add button, active-high.
- `key_sub`  in  1  raw asynchronous sub button, active-high.
- `add_time`  out  1  one-cycle add request to timer.
- `sub_time`  out  1  one-cycle sub request to timer.
- `key_busy`  out  1  FSM not in IDLE.

## Operation

- Per key: 2-flop synchronizer, then debouncer; debounced level flips only after `DEBOUNCE_CYCLES` consecutive synchronized samples differ from it. Debounced levels reset to 0.
- Armed = `power` & ~`enable`.
- FSM states: IDLE, HOLD, REPEAT, WAIT_RELEASE.
- IDLE: debounced rising edge on exactly one key while armed → pulse that key's output, load counter, go HOLD. Both keys debounced-high → WAIT_RELEASE, no pulse. Key rising while not armed → WAIT_RELEASE, no pulse.
- HOLD: counter reaches `REPEAT_DELAY` with same key held → pulse, go REPEAT.
- REPEAT: pulse every `REPEAT_PERIOD` cycles while held.
- HOLD/REPEAT: key released → IDLE; other key becomes high → WAIT_RELEASE; armed drops → WAIT_RELEASE (no further pulses).
- WAIT_RELEASE: both debounced keys low → IDLE.
- `add_time` and `sub_time` never high together; at most one per cycle.
- Counters saturate, never wrap.

## Timing

- All outputs registered; reset value of `add_time`, `sub_time`, `key_busy` = 0; FSM → IDLE, counters → 0, synchronizers → 0.
- Edge 1 = first clock edge sampling raw key high. Debounced level rises at edge 2+`DEBOUNCE_CYCLES`; pulse high during cycle after edge 3+`DEBOUNCE_CYCLES` (defaults: edge 7).
- First repeat pulse `REPEAT_DELAY` cycles after first pulse (edge 15), then every `REPEAT_PERIOD` (19, 23, …).
- Release latency symmetric: debounced low at edge (last-high edge)+2+`DEBOUNCE_CYCLES`; no pulse from that edge on.
- Armed dropping suppresses any pulse from the same edge onward.
- Reset asserted mid-operation: outputs 0 on next edge; a key still held after reset release is treated as a fresh press.

## Configuration

- `ADJUST_AUTO_REPEAT_EN` defined: HOLD/REPEAT behaviour as above.
- Undefined: HOLD waits only for release; exactly one pulse per press; `REPEAT_DELAY`/`REPEAT_PERIOD` unused; REPEAT state absent.

## Structure

- Package `adjust_key_pkg`: FSM state enum, default parameter constants.
- Sub-module `key_debounce` (synchronizer + debouncer, parameter `DEBOUNCE_CYCLES`, `CNT_WIDTH`), instantiated once per key; FSM and repeat counter in top.

## Test plan

- Reset: `reset_n`=0 2 cycles with `key_add`=1 → all outputs 0; after release of reset, `key_add` held → `add_time` pulse 7 edges later.
- Glitch: power=1, enable=0, `key_add` high 3 cycles → no `add_time`, `key_busy` stays 0.
- Single press: `key_add` high edges 1–10 → one `add_time` pulse at edge 7 only; `key_busy` returns 0 after debounced release.
- Auto-repeat: `key_sub` high edges 1–24 → `sub_time` at edges 7, 15, 19, 23, 27 only; without `ADJUST_AUTO_REPEAT_EN` → edge 7 only.
- Both keys together, or press with `enable`=1 or `power`=0 → no pulses, `key_busy`=1 until both released.
- `power` 1→0 during REPEAT → pulses stop same edge, state WAIT_RELEASE until key released.
